// File: rtl/len_unpack.sv
// Unpacks a run-length coded stream of 4-bit code-length symbols into one
// (index, length) entry per table slot and keeps a per-length histogram.
module len_unpack #(
  parameter int TOTAL = 45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  rdata,
  input  logic        rempty,
  output logic        rinc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_idx,
  output logic [3:0]  out_len,
  output logic [47:0] len_hist,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [6:0] TOTAL_W = 7'(TOTAL);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  run_q, run_d;
  logic        esc_q, esc_d;
  logic [47:0] hist_q, hist_d;
  logic [3:0]  len_q, len_d;
  logic        hs_s;
  logic        last_s;
  logic [6:0]  run_end_s;

  // Bump the 6-bit histogram field selected by a nonzero code length.
  function automatic logic [47:0] hist_inc(input logic [47:0] h, input logic [3:0] len);
    logic [47:0] r;
    r = h;
    for (int k = 1; k <= 8; k++) begin
      if (len == 4'(k)) begin
        r[6*k-1 -: 6] = h[6*k-1 -: 6] + 6'd1;
      end else begin
        r[6*k-1 -: 6] = r[6*k-1 -: 6];
      end
    end
    return r;
  endfunction

  assign out_valid = (state_q == EMIT) || (state_q == RUN);
  assign rinc      = (state_q == FETCH) && !rempty && !start;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign out_idx   = idx_q;
  assign out_len   = len_q;
  assign len_hist  = hist_q;

  assign hs_s      = out_valid && out_ready;
  assign last_s    = ({1'b0, idx_q} + 7'd1) == TOTAL_W;
  // Run end is formed at 7 bits so an oversized run cannot wrap past TOTAL.
  assign run_end_s = {1'b0, idx_q} + {3'b000, rdata} + 7'd3;

  // Next-state and datapath update; start overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    esc_d   = esc_q;
    hist_d  = hist_q;
    len_d   = len_q;
    if (start) begin
      state_d = FETCH;
      idx_d   = 6'd0;
      run_d   = 4'd0;
      esc_d   = 1'b0;
      hist_d  = 48'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (rempty) begin
            state_d = FETCH;
          end else if (!esc_q) begin
            if (rdata <= 4'd8) begin
              len_d   = rdata;
              state_d = EMIT;
            end else if (rdata == 4'd9) begin
              esc_d = 1'b1;
            end else begin
              state_d = ERR;
            end
          end else if (rdata <= 4'd7 && run_end_s <= TOTAL_W) begin
            esc_d   = 1'b0;
            run_d   = rdata + 4'd3;
            len_d   = 4'd0;
            state_d = RUN;
          end else begin
            state_d = ERR;
          end
        end
        EMIT: begin
          if (hs_s) begin
            hist_d  = hist_inc(hist_q, len_q);
            idx_d   = idx_q + 6'd1;
            state_d = last_s ? DONE : FETCH;
          end else begin
            state_d = EMIT;
          end
        end
        RUN: begin
          if (hs_s) begin
            run_d = run_q - 4'd1;
            idx_d = idx_q + 6'd1;
            if (run_q == 4'd1) begin
              state_d = last_s ? DONE : FETCH;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      run_q   <= 4'd0;
      esc_q   <= 1'b0;
      hist_q  <= 48'd0;
      len_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      esc_q   <= esc_d;
      hist_q  <= hist_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_len_unpack.sv
// Directed self-checking bench for len_unpack with a FWFT FIFO model and
// an entry logger driven from the output handshake.
module tb_len_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_idx;
  logic [3:0]  out_len;
  logic [47:0] len_hist;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [0:511];
  int rd_ptr = 0;
  int wr_ptr = 0;

  logic       log_clr = 1'b0;
  int         n_log = 0;
  logic [5:0] log_idx [0:63];
  logic [3:0] log_len [0:63];

  len_unpack #(.TOTAL(45)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rdata(rdata), .rempty(rempty),
    .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_len(out_len), .len_hist(len_hist), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rdata  = mem[rd_ptr % 512];
  assign rempty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    if (log_clr) begin
      n_log <= 0;
    end else if (out_valid && out_ready) begin
      if (n_log < 64) begin
        log_idx[n_log] <= out_idx;
        log_len[n_log] <= out_len;
      end
      n_log <= n_log + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 512] = w;
      wr_ptr++;
    end
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    log_clr = 1'b1;
    cyc();
    start   = 1'b0;
    log_clr = 1'b0;
  endtask

  task automatic wait_end(input int max);
    logic prev_hs;
    logic seen;
    prev_hs = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      prev_hs = out_valid & out_ready;
      cyc();
      if (done || err) seen = 1'b1;
    end
    chk("end_seen", 64'(seen), 64'd1);
    if (done) chk("done_latency", 64'(prev_hs), 64'd1);
  endtask

  task automatic wait_entry(input logic [5:0] idx, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      cyc();
      if (out_valid && out_idx == idx) seen = 1'b1;
    end
    chk("entry_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 512; i++) mem[i] = 4'd0;

    // Reset values
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rinc", 64'(rinc), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    chk("rst_hist", 64'(len_hist), 64'd0);
    chk("rst_idx_len", 64'({out_idx, out_len}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(4'd1, 1);
    cyc();
    cyc();
    chk("idle_no_pop", 64'(rinc), 64'd0);
    chk("idle_fifo_kept", 64'(wr_ptr - rd_ptr), 64'd1);
    flush();

    // 45 literal lengths of 1, plus one leftover word
    out_ready = 1'b1;
    push(4'd1, 46);
    pulse_start();
    wait_end(400);
    chk("a_count", 64'(n_log), 64'd45);
    bad = 0;
    for (int i = 0; i < 45; i++)
      if (log_idx[i] !== 6'(i) || log_len[i] !== 4'd1) bad++;
    chk("a_entries", 64'(bad), 64'd0);
    chk("a_hist", 64'(len_hist), 64'd45);
    chk("a_done", 64'({done, err}), 64'b10);
    cyc(); cyc(); cyc();
    chk("a_leftover", 64'(wr_ptr - rd_ptr), 64'd1);
    chk("a_done_hold", 64'({done, rinc, out_valid}), 64'b100);

    // Escape run of 10 zeros, then 35 lengths of 2
    flush();
    push(4'd9, 1);
    push(4'd7, 1);
    push(4'd2, 35);
    pulse_start();
    wait_end(400);
    chk("b_count", 64'(n_log), 64'd45);
    bad = 0;
    for (int i = 0; i < 45; i++)
      if (log_idx[i] !== 6'(i) || log_len[i] !== ((i < 10) ? 4'd0 : 4'd2)) bad++;
    chk("b_entries", 64'(bad), 64'd0);
    chk("b_hist", 64'(len_hist), 64'(48'd35 << 6));
    chk("b_done", 64'({done, err}), 64'b10);

    // Backpressure during EMIT
    flush();
    out_ready = 1'b0;
    push(4'd4, 3);
    pulse_start();
    wait_entry(6'd0, 10);
    for (int i = 0; i < 5; i++) begin
      chk("c_hold_out", 64'({out_valid, out_idx, out_len}), 64'({1'b1, 6'd0, 4'd4}));
      chk("c_hold_rinc", 64'(rinc), 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    chk("c_next", 64'({out_valid, out_idx, out_len}), 64'({1'b1, 6'd1, 4'd4}));
    chk("c_hist", 64'(len_hist), 64'(48'd1 << 18));

    // Run that would overshoot the table
    flush();
    out_ready = 1'b1;
    push(4'd3, 42);
    push(4'd9, 1);
    push(4'd1, 1);
    pulse_start();
    wait_end(400);
    chk("d_err", 64'({done, err}), 64'b01);
    chk("d_count", 64'(n_log), 64'd42);
    chk("d_hist", 64'(len_hist), 64'(48'd42 << 12));

    // Double escape, then a bad literal
    flush();
    push(4'd9, 2);
    pulse_start();
    wait_end(20);
    chk("e1_err", 64'({done, err}), 64'b01);
    chk("e1_count", 64'(n_log), 64'd0);
    flush();
    push(4'd5, 1);
    push(4'd12, 1);
    pulse_start();
    wait_end(20);
    chk("e2_err", 64'({done, err}), 64'b01);
    chk("e2_count", 64'(n_log), 64'd1);
    chk("e2_entry", 64'({log_idx[0], log_len[0]}), 64'({6'd0, 4'd5}));
    chk("e2_hist", 64'(len_hist), 64'(48'd1 << 24));
    push(4'd1, 1);
    cyc(); cyc();
    chk("e2_err_hold", 64'({err, rinc, out_valid}), 64'b100);
    chk("e2_fifo_kept", 64'(wr_ptr - rd_ptr), 64'd1);

    // Restart mid-RUN, then async reset mid-EMIT
    flush();
    push(4'd5, 1);
    push(4'd9, 1);
    push(4'd7, 1);
    pulse_start();
    wait_entry(6'd3, 20);
    chk("f_in_run", 64'({out_valid, out_len}), 64'({1'b1, 4'd0}));
    chk("f_hist_pre", 64'(len_hist), 64'(48'd1 << 24));
    start = 1'b1;
    flush();
    cyc();
    start = 1'b0;
    chk("f_restart", 64'({out_valid, out_idx, done, err}), 64'd0);
    chk("f_restart_hist", 64'(len_hist), 64'd0);
    push(4'd6, 2);
    wait_entry(6'd1, 20);
    out_ready = 1'b0;
    chk("f_emit", 64'({out_valid, out_len}), 64'({1'b1, 4'd6}));
    chk("f_hist_emit", 64'(len_hist), 64'(48'd1 << 30));
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_out", 64'({out_valid, out_idx, out_len, rinc}), 64'd0);
    chk("f_rst_hist", 64'(len_hist), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    push(4'd2, 1);
    cyc(); cyc();
    chk("f_idle", 64'({out_valid, rinc, done, err}), 64'd0);
    pulse_start();
    cyc();
    chk("f_fresh", 64'({out_valid, out_idx, out_len}), 64'({1'b1, 6'd0, 4'd2}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
